// File: rtl/store_drain_if.sv
// -----------------------------------------------------------------------------
// store_drain_if
// Bundles the signals between the store pipeline, the store drain buffer and
// the data-memory/IO port.
//   Upstream side : rd_in, io_out_addr_in, memory_we_in, fence_sig_in,
//                   fence_mode_in (in), stall_out, fence_done_out,
//                   fence_mode_out, count_out (out)
//   Memory side   : mem_req_out, mem_addr_out, mem_wdata_out (out),
//                   mem_ack_in (in)
// The master modport belongs to the environment (pipeline + memory); the slave
// modport belongs to the buffer itself.
// -----------------------------------------------------------------------------
interface store_drain_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] rd_in;
    logic [XLEN-1:0] io_out_addr_in;
    logic            memory_we_in;
    logic [7:0]      fence_sig_in;
    logic [3:0]      fence_mode_in;
    logic            mem_req_out;
    logic [XLEN-1:0] mem_addr_out;
    logic [XLEN-1:0] mem_wdata_out;
    logic            mem_ack_in;
    logic            stall_out;
    logic            fence_done_out;
    logic [3:0]      fence_mode_out;
    logic [CW-1:0]   count_out;

    modport master (
        output rd_in, io_out_addr_in, memory_we_in, fence_sig_in,
               fence_mode_in, mem_ack_in,
        input  mem_req_out, mem_addr_out, mem_wdata_out, stall_out,
               fence_done_out, fence_mode_out, count_out
    );

    modport slave (
        input  rd_in, io_out_addr_in, memory_we_in, fence_sig_in,
               fence_mode_in, mem_ack_in,
        output mem_req_out, mem_addr_out, mem_wdata_out, stall_out,
               fence_done_out, fence_mode_out, count_out
    );
endinterface

// File: rtl/store_drain_buffer.sv
// -----------------------------------------------------------------------------
// store_drain_buffer
// Queues committed stores from the store pipeline register in a small FIFO and
// drains them to memory over a req/ack handshake. A fence drains every buffered
// store before a one-cycle completion pulse is raised.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : store_drain_if.slave (store inputs, fence inputs, memory handshake,
//          stall / fence completion / occupancy outputs)
// -----------------------------------------------------------------------------
module store_drain_buffer #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    store_drain_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] r_addr_mem [DEPTH];
    logic [XLEN-1:0] r_data_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_addr_out;
    logic [XLEN-1:0] r_wdata_out;
    logic [3:0]      r_fence_mode;
    logic [3:0]      r_fence_mode_out;

    logic            w_stall;
    logic            w_push;
    logic            w_pop;
    logic            w_fence_accept;
    logic [CW-1:0]   w_count_after_pop;
    logic [CW-1:0]   w_count_next;
    logic [PW-1:0]   w_rd_ptr_next;

    // Stall depends on registered state only, so there is no input-to-stall path.
    assign w_stall           = (r_count == CW'(DEPTH)) || (r_state != S_IDLE);
    assign w_push            = bus.memory_we_in && !w_stall;
    assign w_pop             = bus.mem_ack_in && (r_count != '0);
    assign w_fence_accept    = (r_state == S_IDLE) && (bus.fence_sig_in != 8'd0) && !w_stall;
    assign w_count_after_pop = r_count - CW'(w_pop);
    assign w_count_next      = w_count_after_pop + CW'(w_push);
    assign w_rd_ptr_next     = r_rd_ptr + PW'(w_pop);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fence_accept) w_state_next = S_DRAIN;
            // A pop on this edge that empties the buffer completes the fence.
            S_DRAIN: if (w_count_next == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Entry storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= bus.io_out_addr_in;
            r_data_mem[r_wr_ptr] <= bus.rd_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_addr_out       <= '0;
            r_wdata_out      <= '0;
            r_fence_mode     <= '0;
            r_fence_mode_out <= '0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_rd_ptr <= w_rd_ptr_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_fence_accept) r_fence_mode <= bus.fence_mode_in;
            if ((r_state == S_DRAIN) && (w_state_next == S_DONE))
                r_fence_mode_out <= r_fence_mode;
            // Registered head read. If the buffer is empty after this edge's pop,
            // the incoming store becomes the head and is bypassed straight in;
            // if nothing remains at all the last presented values are held.
            if (w_push && (w_count_after_pop == '0)) begin
                r_addr_out  <= bus.io_out_addr_in;
                r_wdata_out <= bus.rd_in;
            end else if (w_count_after_pop != '0) begin
                r_addr_out  <= r_addr_mem[w_rd_ptr_next];
                r_wdata_out <= r_data_mem[w_rd_ptr_next];
            end
        end
    end

    assign bus.mem_req_out    = (r_count != '0);
    assign bus.mem_addr_out   = r_addr_out;
    assign bus.mem_wdata_out  = r_wdata_out;
    assign bus.stall_out      = w_stall;
    assign bus.fence_done_out = (r_state == S_DONE);
    assign bus.fence_mode_out = r_fence_mode_out;
    assign bus.count_out      = r_count;
endmodule

// File: tb/tb_store_drain_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_drain_buffer
// Drives directed and randomized store/fence/ack traffic into store_drain_buffer
// and compares every output each cycle against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_store_drain_buffer;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    store_drain_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    store_drain_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents as a queue of {addr, data}, plus fence phase.
    logic [127:0] m_q [$];
    bit           m_drain;
    bit           m_done;
    logic [3:0]   m_mode;
    logic [3:0]   m_mode_out;
    logic [63:0]  m_addr_shown;
    logic [63:0]  m_data_shown;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_stall();
        return (m_q.size() == DEPTH) || m_drain || m_done;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_drain      = 1'b0;
        m_done       = 1'b0;
        m_mode       = '0;
        m_mode_out   = '0;
        m_addr_shown = '0;
        m_data_shown = '0;
    endtask

    task automatic check_outputs();
        bit have;
        logic [63:0] ea;
        logic [63:0] ed;
        have = (m_q.size() != 0);
        ea   = have ? m_q[0][127:64] : m_addr_shown;
        ed   = have ? m_q[0][63:0]   : m_data_shown;
        chk("req",   bus.mem_req_out,    have);
        chk("addr",  bus.mem_addr_out,   ea);
        chk("wdata", bus.mem_wdata_out,  ed);
        chk("stall", bus.stall_out,      m_stall());
        chk("done",  bus.fence_done_out, m_done);
        chk("mode",  bus.fence_mode_out, m_mode_out);
        chk("count", bus.count_out,      m_q.size());
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance model.
    task automatic step(input logic we, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] fs, input logic [3:0] fm, input logic ack,
                        output bit acc);
        bit st;
        bit push;
        bit pop;
        bus.memory_we_in   = we;
        bus.io_out_addr_in = a;
        bus.rd_in          = d;
        bus.fence_sig_in   = fs;
        bus.fence_mode_in  = fm;
        bus.mem_ack_in     = ack;
        @(negedge clk);
        check_outputs();
        st   = m_stall();
        acc  = !st;
        push = we && !st;
        pop  = ack && (m_q.size() != 0);
        if (m_q.size() != 0) begin
            m_addr_shown = m_q[0][127:64];
            m_data_shown = m_q[0][63:0];
        end
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({a, d});
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_drain) begin
            if (m_q.size() == 0) begin
                m_drain    = 1'b0;
                m_done     = 1'b1;
                m_mode_out = m_mode;
            end
        end else if ((fs != 8'd0) && !st) begin
            m_drain = 1'b1;
            m_mode  = fm;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ack);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 8'd0, 4'd0, ack, acc);
    endtask

    // Present a store and hold it until accepted (bounded).
    task automatic put(input logic [63:0] a, input logic [63:0] d, input logic ack);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 30) begin
            step(1'b1, a, d, 8'd0, 4'd0, ack, acc);
            tries++;
        end
        if (!acc) chk("put_timeout", 1'b0, 1'b1);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic rst_mid();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_count", bus.count_out,      '0);
        chk("rst_req",   bus.mem_req_out,    1'b0);
        chk("rst_stall", bus.stall_out,      1'b0);
        chk("rst_addr",  bus.mem_addr_out,   '0);
        chk("rst_done",  bus.fence_done_out, 1'b0);
        model_reset();
        bus.memory_we_in = 1'b0;
        bus.fence_sig_in = 8'd0;
        bus.mem_ack_in   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        bit p_we;
        logic [63:0] p_a;
        logic [63:0] p_d;
        logic [7:0]  p_fs;
        logic [3:0]  p_fm;

        rst = 1'b1;
        bus.memory_we_in   = 1'b0;
        bus.io_out_addr_in = '0;
        bus.rd_in          = '0;
        bus.fence_sig_in   = 8'd0;
        bus.fence_mode_in  = 4'd0;
        bus.mem_ack_in     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single store with ack tied high.
        step(1'b1, 64'h1000, 64'hDEADBEEF, 8'd0, 4'd0, 1'b1, acc);
        idle(2, 1'b1);

        // Fill to full, fifth store held until a slot frees.
        for (int i = 0; i < 4; i++) put(64'(i * 8), 64'hA000 + 64'(i), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 64'h20, 64'hA004, 8'd0, 4'd0, 1'b0, acc);
        put(64'h20, 64'hA004, 1'b1);
        idle(6, 1'b1);

        // Enqueue+pop at count 2 across pointer wrap.
        put(64'h100, 64'hB0, 1'b0);
        put(64'h108, 64'hB1, 1'b0);
        for (int i = 0; i < 10; i++) put(64'h200 + 64'(i * 8), 64'hC0 + 64'(i), 1'b1);
        idle(4, 1'b1);

        // Two stores then fence 0x33 / mode 0, ack every fourth cycle.
        put(64'h300, 64'hD0, 1'b0);
        put(64'h308, 64'hD1, 1'b0);
        step(1'b0, '0, '0, 8'h33, 4'h0, 1'b0, acc);
        for (int k = 0; k < 12; k++) step(1'b0, '0, '0, 8'd0, 4'd0, (k % 4) == 3, acc);

        // Store + fence in the same cycle on an empty buffer, mode 8.
        step(1'b1, 64'h400, 64'hE0, 8'h11, 4'h8, 1'b0, acc);
        for (int k = 0; k < 6; k++) step(1'b0, '0, '0, 8'd0, 4'd0, k == 1, acc);

        // Fence alone on an empty buffer.
        step(1'b0, '0, '0, 8'h01, 4'h5, 1'b0, acc);
        idle(4, 1'b0);

        // Reset mid-stream with three entries queued; they must never drain.
        for (int i = 0; i < 3; i++) put(64'h500 + 64'(i * 8), 64'hF0 + 64'(i), 1'b0);
        rst_mid();
        idle(4, 1'b1);

        // Randomized traffic, obeying the hold-while-stalled rule.
        p_we = 1'b0; p_a = '0; p_d = '0; p_fs = 8'd0; p_fm = 4'd0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                rst_mid();
                p_we = 1'b0;
                p_fs = 8'd0;
            end
            if (!p_we && p_fs == 8'd0) begin
                p_we = 1'($urandom_range(0, 1));
                p_a  = {$urandom, $urandom};
                p_d  = {$urandom, $urandom};
                if ($urandom_range(0, 15) == 0) begin
                    p_fs = 8'($urandom_range(1, 255));
                    p_fm = 4'($urandom);
                end
            end
            step(p_we, p_a, p_d, p_fs, p_fm, $urandom_range(0, 2) != 0, acc);
            if (acc) begin
                p_we = 1'b0;
                p_fs = 8'd0;
            end
        end
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
